order_ctrl: RTL and testbench

ORDER_CTRL -- requirements
Module: order_ctrl

---
 rtl/order_ctrl_pkg.sv | 42 ++++
 rtl/order_ctrl_hold_counter.sv | 36 +++
 rtl/order_ctrl.sv | 174 +++++++++++++++++
 tb/tb_order_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_ctrl_pkg.sv
// Shared definitions for the order-entry controller: FSM states, display modes,
// key codes, pricing and field limits.
package order_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_QTY,
        S_CALC,
        S_TOTAL,
        S_FINISH
    } state_t;

    localparam logic [2:0] MODE_IDLE   = 3'b000;
    localparam logic [2:0] MODE_CODE   = 3'b001;
    localparam logic [2:0] MODE_QTY    = 3'b010;
    localparam logic [2:0] MODE_TOTAL  = 3'b011;
    localparam logic [2:0] MODE_FINISH = 3'b100;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_ADD    = 4'hC;
    localparam logic [3:0] KEY_DONE   = 4'hD;
    localparam logic [3:0] KEY_CANCEL = 4'hE;

    localparam int unsigned PRICE_BASE = 100;
    localparam int unsigned CODE_MAX   = 999;
    localparam int unsigned QTY_MAX    = 99;
    localparam int unsigned TOTAL_MAX  = 99999;

    // CALC shares the quantity display so the operator still sees the line being added.
    function automatic logic [2:0] mode_of(input state_t s);
        case (s)
            S_CODE:         mode_of = MODE_CODE;
            S_QTY, S_CALC:  mode_of = MODE_QTY;
            S_TOTAL:        mode_of = MODE_TOTAL;
            S_FINISH:       mode_of = MODE_FINISH;
            default:        mode_of = MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/order_ctrl_hold_counter.sv
// Generic hold counter: start begins a run, clear aborts it, done stays high
// from the CYCLES-th cycle after start until cleared.
module hold_counter #(
    parameter int unsigned CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic done
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt;
    logic         running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (clear) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running && !done) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = running && (cnt == LAST);

endmodule

// File: rtl/order_ctrl.sv
// Keypad order controller: code/quantity entry, per-line total accumulation and
// a timed finish display. Define ORDER_TIMEOUT_EN to abandon idle orders.
module order_ctrl
    import order_ctrl_pkg::*;
#(
    parameter int unsigned FINISH_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [2:0]  mode,
    output logic [9:0]  cn_now,
    output logic [6:0]  qty_now,
    output logic [16:0] total_sum,
    output logic        busy
);

    state_t      state, state_n;
    logic [9:0]  cn_n;
    logic [6:0]  qty_n;
    logic [6:0]  calc_left, calc_left_n;
    logic [16:0] total_n;
    logic        wipe;

    logic        is_digit;
    logic [13:0] code_ext;
    logic [9:0]  qty_ext;
    logic [17:0] sum_ext;

    logic fin_start, fin_clear, fin_done;
    logic tmo_start, tmo_clear, tmo_done;
    logic active_now, active_next;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign code_ext = {4'd0, cn_now} * 14'd10 + {10'd0, key_code};
    assign qty_ext  = {3'd0, qty_now} * 10'd10 + {6'd0, key_code};
    assign sum_ext  = {1'b0, total_sum} + 18'(PRICE_BASE) + {8'd0, cn_now};

    always_comb begin
        state_n     = state;
        cn_n        = cn_now;
        qty_n       = qty_now;
        total_n     = total_sum;
        calc_left_n = calc_left;
        wipe        = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_digit) begin
                    state_n = S_CODE;
                    cn_n    = {6'd0, key_code};
                    qty_n   = '0;
                    total_n = '0;
                end
            end
            S_CODE: begin
                if (is_digit) begin
                    if (code_ext <= 14'(CODE_MAX)) cn_n = code_ext[9:0];
                end else if (key_valid) begin
                    case (key_code)
                        KEY_CLEAR:  cn_n = '0;
                        KEY_ENTER: begin
                            state_n = S_QTY;
                            qty_n   = '0;
                        end
                        KEY_CANCEL: wipe = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_QTY: begin
                if (is_digit) begin
                    if (qty_ext <= 10'(QTY_MAX)) qty_n = qty_ext[6:0];
                end else if (key_valid) begin
                    case (key_code)
                        KEY_CLEAR:  qty_n = '0;
                        KEY_ENTER: begin
                            if (qty_now != 7'd0) begin
                                state_n     = S_CALC;
                                calc_left_n = qty_now;
                            end
                        end
                        KEY_CANCEL: wipe = 1'b1;
                        default: ;
                    endcase
                end
            end
            // One price added per cycle; keys are deliberately not decoded here.
            S_CALC: begin
                total_n     = (sum_ext > 18'(TOTAL_MAX)) ? 17'(TOTAL_MAX) : sum_ext[16:0];
                calc_left_n = calc_left - 7'd1;
                if (calc_left == 7'd1) state_n = S_TOTAL;
            end
            S_TOTAL: begin
                if (key_valid) begin
                    case (key_code)
                        KEY_ADD: begin
                            state_n = S_CODE;
                            cn_n    = '0;
                            qty_n   = '0;
                        end
                        KEY_DONE:   state_n = S_FINISH;
                        KEY_CANCEL: wipe = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_FINISH: begin
                if (fin_done) wipe = 1'b1;
            end
            default: wipe = 1'b1;
        endcase
        // A key arriving on the expiry cycle counts as activity and wins.
        if (tmo_done && !key_valid) wipe = 1'b1;
        if (wipe) begin
            state_n = S_IDLE;
            cn_n    = '0;
            qty_n   = '0;
            total_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cn_now    <= '0;
            qty_now   <= '0;
            total_sum <= '0;
            calc_left <= '0;
            busy      <= 1'b0;
            mode      <= MODE_IDLE;
        end else begin
            state     <= state_n;
            cn_now    <= cn_n;
            qty_now   <= qty_n;
            total_sum <= total_n;
            calc_left <= calc_left_n;
            busy      <= (state_n == S_CALC);
            mode      <= mode_of(state_n);
        end
    end

    assign fin_start   = (state_n == S_FINISH) && (state != S_FINISH);
    assign fin_clear   = (state_n != S_FINISH);
    assign active_now  = (state inside {S_CODE, S_QTY, S_TOTAL});
    assign active_next = (state_n inside {S_CODE, S_QTY, S_TOTAL});

`ifdef ORDER_TIMEOUT_EN
    assign tmo_start = active_next && (key_valid || !active_now);
    assign tmo_clear = !active_next;
`else
    // Held cleared so done never rises and the counter reduces to nothing.
    assign tmo_start = 1'b0;
    assign tmo_clear = 1'b1 | active_now | active_next;
`endif

    hold_counter #(.CYCLES(FINISH_CYCLES)) u_finish (
        .clk   (clk),
        .rst_n (rst_n),
        .start (fin_start),
        .clear (fin_clear),
        .done  (fin_done)
    );

    hold_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tmo_start),
        .clear (tmo_clear),
        .done  (tmo_done)
    );

endmodule

// File: tb/tb_order_ctrl.sv
// Self-checking bench for order_ctrl against a key-level order model.
// Build with ORDER_TIMEOUT_EN defined to exercise the inactivity timeout.
module tb_order_ctrl;

    localparam int FIN = 8;
    localparam int TMO = 16;

    localparam int M_IDLE   = 0;
    localparam int M_CODE   = 1;
    localparam int M_QTY    = 2;
    localparam int M_CALC   = 3;
    localparam int M_TOTAL  = 4;
    localparam int M_FINISH = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [2:0]  mode;
    logic [9:0]  cn_now;
    logic [6:0]  qty_now;
    logic [16:0] total_sum;
    logic        busy;
    logic [37:0] obs;

    int errors = 0;
    int checks = 0;

    int m_st = M_IDLE;
    int m_cn = 0;
    int m_qty = 0;
    int m_total = 0;

    order_ctrl #(.FINISH_CYCLES(FIN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .mode      (mode),
        .cn_now    (cn_now),
        .qty_now   (qty_now),
        .total_sum (total_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign obs = {mode, cn_now, qty_now, total_sum, busy};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic logic [37:0] exp_vec();
        logic [2:0] md;
        case (m_st)
            M_IDLE:        md = 3'd0;
            M_CODE:        md = 3'd1;
            M_QTY, M_CALC: md = 3'd2;
            M_TOTAL:       md = 3'd3;
            default:       md = 3'd4;
        endcase
        return {md, 10'(m_cn), 7'(m_qty), 17'(m_total), (m_st == M_CALC)};
    endfunction

    function automatic void model_zero();
        m_st = M_IDLE;
        m_cn = 0;
        m_qty = 0;
        m_total = 0;
    endfunction

    function automatic void model_key(input int k);
        case (m_st)
            M_IDLE: if (k <= 9) begin
                m_st = M_CODE; m_cn = k; m_qty = 0; m_total = 0;
            end
            M_CODE: begin
                if (k <= 9) begin
                    if (m_cn * 10 + k <= 999) m_cn = m_cn * 10 + k;
                end else if (k == 11) m_cn = 0;
                else if (k == 10) begin m_st = M_QTY; m_qty = 0; end
                else if (k == 14) model_zero();
            end
            M_QTY: begin
                if (k <= 9) begin
                    if (m_qty * 10 + k <= 99) m_qty = m_qty * 10 + k;
                end else if (k == 11) m_qty = 0;
                else if (k == 10 && m_qty > 0) m_st = M_CALC;
                else if (k == 14) model_zero();
            end
            M_TOTAL: begin
                if (k == 12) begin m_st = M_CODE; m_cn = 0; m_qty = 0; end
                else if (k == 13) m_st = M_FINISH;
                else if (k == 14) model_zero();
            end
            default: ;
        endcase
    endfunction

    task automatic press(input int k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code = 4'(k);
        @(negedge clk);
        key_valid = 1'b0;
        model_key(k);
    endtask

    // Entered right after the ENTER that starts a line; busy must hold for qty cycles.
    task automatic test_calc_phase(input bit noise, input string tag);
        int n;
        int t;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (noise) begin
                key_valid = 1'($urandom_range(0, 1));
                key_code = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        checks++;
        if (n !== m_qty) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d, want %0d", tag, n, m_qty);
        end
        t = m_total + m_qty * (100 + m_cn);
        m_total = (t > 99999) ? 99999 : t;
        m_st = M_TOTAL;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL %s_total: got %h, want %h (total %0d want %0d)", tag, obs, exp_vec(), total_sum, m_total);
        end
    endtask

    task automatic test_finish_phase(input bit noise, input string tag);
        int n;
        n = 0;
        while (mode === 3'd4 && n < 100) begin
            n++;
            if (noise) begin
                key_valid = 1'($urandom_range(0, 1));
                key_code = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        checks++;
        if (n !== FIN) begin
            errors++;
            $display("FAIL %s_finish_cycles: got %0d, want %0d", tag, n, FIN);
        end
        model_zero();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL %s_after_finish: got %h, want %h", tag, obs, exp_vec());
        end
    endtask

    task automatic test_reset();
        #12;
        key_valid = 1'b1;
        key_code = 4'd5;
        @(negedge clk);
        model_zero();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state: got %h, want %h", obs, exp_vec());
        end
        // Release with a key already present: it must land on the first edge.
        key_code = 4'd7;
        rst_n = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        model_key(7);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL first_key_after_reset: got %h, want %h", obs, exp_vec());
        end
        press(14);
    endtask

    task automatic test_code_entry();
        int seq[] = '{1, 2, 3, 4, 11, 15, 9, 10, 10, 5, 11, 14};
        foreach (seq[i]) begin
            press(seq[i]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL code_entry_step%0d key %0d: got %h, want %h", i, seq[i], obs, exp_vec());
            end
        end
    endtask

    task automatic test_basic_order();
        int seq[] = '{1, 2, 10, 3};
        foreach (seq[i]) press(seq[i]);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL basic_before_enter: got %h, want %h", obs, exp_vec());
        end
        press(10);
        test_calc_phase(1'b0, "basic");
    endtask

    task automatic test_add_done();
        int seq[] = '{12, 5, 10, 2};
        foreach (seq[i]) press(seq[i]);
        press(10);
        test_calc_phase(1'b0, "add");
        checks++;
        if (total_sum !== 17'd546) begin
            errors++;
            $display("FAIL add_total_546: got %0d, want 546", total_sum);
        end
        press(13);
        test_finish_phase(1'b0, "done");
    endtask

    task automatic test_saturation();
        int seq[] = '{9, 9, 9, 9, 10, 9, 9, 9};
        foreach (seq[i]) press(seq[i]);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL sat_fields: got %h, want %h", obs, exp_vec());
        end
        press(10);
        test_calc_phase(1'b0, "sat");
        checks++;
        if (total_sum !== 17'd99999) begin
            errors++;
            $display("FAIL sat_total: got %0d, want 99999", total_sum);
        end
        press(14);
    endtask

    task automatic test_calc_cancel_and_reset();
        int seq[] = '{1, 2, 10, 3};
        foreach (seq[i]) press(seq[i]);
        press(10);
        test_calc_phase(1'b1, "cancel_in_calc");
        press(14);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL cancel_in_total: got %h, want %h", obs, exp_vec());
        end
        press(4); press(10); press(9); press(9); press(10);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_zero();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_calc: got %h, want %h", obs, exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL after_reset_mid_calc: got %h, want %h", obs, exp_vec());
        end
    endtask

`ifdef ORDER_TIMEOUT_EN
    task automatic test_timeout();
        press(4);
        press(10);
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (mode !== 3'd2) begin
            errors++;
            $display("FAIL timeout_early: mode %0d, want 2", mode);
        end
        key_valid = 1'b1;
        key_code = 4'hF;
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_restart: got %h, want %h", obs, exp_vec());
        end
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (mode !== 3'd2) begin
            errors++;
            $display("FAIL timeout_hold_after_key: mode %0d, want 2", mode);
        end
        @(negedge clk);
        model_zero();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_expire: got %h, want %h", obs, exp_vec());
        end
    endtask
`else
    task automatic test_persist();
        press(4);
        press(10);
        repeat (TMO * 3) @(negedge clk);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL qty_persist: got %h, want %h", obs, exp_vec());
        end
        press(14);
    endtask
`endif

    task automatic test_random();
        int k;
        for (int i = 0; i < 250; i++) begin
            k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            if (m_st == M_QTY && $urandom_range(0, 2) == 0) k = 10;
            if (m_st == M_TOTAL && $urandom_range(0, 1) == 0) k = 12;
            press(k);
            if (m_st == M_CALC) test_calc_phase(1'b1, "rnd");
            else if (m_st == M_FINISH) test_finish_phase(1'b1, "rnd");
            else begin
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL rnd_step%0d key %0d: got %h, want %h", i, k, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_code_entry();
        test_basic_order();
        test_add_done();
        test_saturation();
        test_calc_cancel_and_reset();
`ifdef ORDER_TIMEOUT_EN
        test_timeout();
`else
        test_persist();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
